// File: rtl/rs_codeword_serializer.sv
// Captures whole RS(68,64) codewords into a 2-entry buffer and streams them out as BEAT_BYTES-wide beats.
// Latency: beat 0 is presented the cycle after vld_in; a codeword drains in BEATS accepted beats.
// Backpressure: m_ready stalls the stream; with both entries full a new codeword is dropped and overflow pulses.
module rs_codeword_serializer #(
    parameter int BEAT_BYTES = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [511:0]            msg_in,
    input  logic [31:0]             parity_in,
    input  logic                    vld_in,
    output logic [8*BEAT_BYTES-1:0] m_data,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic                    m_sof,
    output logic                    m_last,
    output logic                    overflow
);

    localparam int BEATS = 68 / BEAT_BYTES;
    localparam int BW    = 8 * BEAT_BYTES;
    localparam int IW    = $clog2(BEATS);
    localparam logic [IW-1:0] LAST_IDX = IW'(BEATS - 1);

    logic [543:0]  buf_q [2];
    logic          wr_ptr;
    logic          rd_ptr;
    logic [1:0]    count;
    logic [IW-1:0] beat_idx;

    logic          accept;
    logic          pop_last;
    logic          wr_en;
    logic [543:0]  head;
    logic [9:0]    bit_base;

    assign m_valid  = (count != 2'd0);
    assign accept   = m_valid & m_ready;
    assign pop_last = accept & (beat_idx == LAST_IDX);
    // A full buffer still takes the input when the head frees its entry this cycle.
    assign wr_en    = vld_in & ((count != 2'd2) | pop_last);

    // Payload storage carries no reset; validity lives entirely in count.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            buf_q[wr_ptr] <= {parity_in, msg_in};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            count    <= 2'd0;
            beat_idx <= '0;
            overflow <= 1'b0;
        end else begin
            overflow <= vld_in & ~wr_en;
            count    <= count + {1'b0, wr_en} - {1'b0, pop_last};
            if (wr_en) begin
                wr_ptr <= ~wr_ptr;
            end
            if (pop_last) begin
                beat_idx <= '0;
                rd_ptr   <= ~rd_ptr;
            end else if (accept) begin
                beat_idx <= beat_idx + IW'(1);
            end
        end
    end

    assign head     = buf_q[rd_ptr];
    assign bit_base = 10'(beat_idx) * 10'(BW);

    // Gating with m_valid keeps stale buffer contents off the bus during and after reset.
    assign m_data = m_valid ? head[bit_base +: BW] : '0;
    assign m_sof  = m_valid & (beat_idx == '0);
    assign m_last = m_valid & (beat_idx == LAST_IDX);

endmodule
